// File: rtl/nrf_ce_pkg.sv
// Shared constants, register map and timer state encoding for the nRF24L01+ CE pulser.
package nrf_ce_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PULSE  = 2'd1;
  localparam logic [1:0] ADDR_HOLD   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_CE_STATIC = 0;
  localparam int CTRL_START     = 1;
  localparam int CTRL_IRQ_EN    = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_OUT     = 3;

  localparam int unsigned DEF_PULSE = 500;
  localparam int unsigned DEF_HOLD  = 6500;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } ce_state_e;

endpackage

// File: rtl/nrf_ce_timer.sv
// CE pulse sequencer: one down-counter shared by the pulse and settle hold-off phases.
module nrf_ce_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] pulse_len,
  input  logic [CNT_W-1:0] hold_len,
  output logic             busy,
  output logic             pulse_active,
  output logic             done_pulse
);
  import nrf_ce_pkg::*;

  ce_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output is defaulted first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_pulse = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PULSE;
          // A zero length still yields a one-cycle pulse.
          cnt_d   = (pulse_len == '0) ? '0 : pulse_len - 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          if (hold_len == '0) begin
            state_d    = IDLE;
            done_pulse = 1'b1;
          end else begin
            state_d = HOLD;
            cnt_d   = hold_len - 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d    = IDLE;
          done_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every flop sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign pulse_active = (state_q == PULSE);

endmodule

// File: rtl/nrf_ce_pulser.sv
// Avalon-MM CE pin controller: register file, bus decode and read mux around nrf_ce_timer.
module nrf_ce_pulser #(
  parameter int          CNT_W     = 16,
  parameter int unsigned DEF_PULSE = nrf_ce_pkg::DEF_PULSE,
  parameter int unsigned DEF_HOLD  = nrf_ce_pkg::DEF_HOLD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);
  import nrf_ce_pkg::*;

  logic             ce_static_q, ce_static_d;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] pulse_len_q, pulse_len_d;
  logic [CNT_W-1:0] hold_len_q, hold_len_d;

  logic busy, pulse_active, done_pulse;
  logic wr, wr_ctrl, wr_pulse, wr_hold, wr_status, start;
  logic unused_wdata;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && (address == ADDR_CTRL);
  assign wr_pulse  = wr && (address == ADDR_PULSE);
  assign wr_hold   = wr && (address == ADDR_HOLD);
  assign wr_status = wr && (address == ADDR_STATUS);
  assign start     = wr_ctrl & writedata[CTRL_START];

  assign unused_wdata = &{1'b0, writedata[31:CNT_W]};

  nrf_ce_timer #(.CNT_W(CNT_W)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pulse_len    (pulse_len_q),
    .hold_len     (hold_len_q),
    .busy         (busy),
    .pulse_active (pulse_active),
    .done_pulse   (done_pulse)
  );

  always_comb begin
    ce_static_d = ce_static_q;
    irq_en_d    = irq_en_q;
    pulse_len_d = pulse_len_q;
    hold_len_d  = hold_len_q;
    done_d      = done_q;
    overrun_d   = overrun_q;
    if (wr_ctrl) begin
      ce_static_d = writedata[CTRL_CE_STATIC];
      irq_en_d    = writedata[CTRL_IRQ_EN];
    end
    if (wr_pulse) pulse_len_d = writedata[CNT_W-1:0];
    if (wr_hold)  hold_len_d  = writedata[CNT_W-1:0];
    // Sticky bits: clear first so a coincident hardware set wins.
    if (wr_status && writedata[ST_DONE])    done_d    = 1'b0;
    if (wr_status && writedata[ST_OVERRUN]) overrun_d = 1'b0;
    if (done_pulse)    done_d    = 1'b1;
    if (start && busy) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ce_static_q <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      pulse_len_q <= CNT_W'(DEF_PULSE);
      hold_len_q  <= CNT_W'(DEF_HOLD);
    end else begin
      ce_static_q <= ce_static_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      pulse_len_q <= pulse_len_d;
      hold_len_q  <= hold_len_d;
    end
  end

  assign out_port = ce_static_q | pulse_active;
  assign irq      = done_q & irq_en_q;

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_CTRL: begin
        readdata[CTRL_CE_STATIC] = ce_static_q;
        readdata[CTRL_IRQ_EN]    = irq_en_q;
      end
      ADDR_PULSE: readdata = 32'(pulse_len_q);
      ADDR_HOLD:  readdata = 32'(hold_len_q);
      ADDR_STATUS: begin
        readdata[ST_BUSY]    = busy;
        readdata[ST_DONE]    = done_q;
        readdata[ST_OVERRUN] = overrun_q;
        readdata[ST_OUT]     = out_port;
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nrf_ce_pulser.sv
// Scoreboard bench for nrf_ce_pulser: probes and CE pulse widths are checked against queued expectations.
module tb_nrf_ce_pulser;

  localparam logic [1:0] A_CTRL = 2'd0, A_PULSE = 2'd1, A_HOLD = 2'd2, A_STATUS = 2'd3;

  typedef struct {
    string       name;
    bit          is_pin;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        out_port;
  logic        irq;

  logic probe = 1'b0;
  exp_t exp_q[$];
  int   pulse_q[$];
  int   cyc = 0;
  int   rise_cyc = 0;
  int   total = 0;
  int   bad = 0;

  nrf_ce_pulser dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every probe against the oldest queued expectation.
  always @(negedge clk) begin
    if (probe) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL probe_underflow: got a probe with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, e.is_pin ? {30'b0, irq, out_port} : readdata, e.val);
      end
    end
  end

  always @(posedge out_port) rise_cyc = cyc;

  always @(negedge out_port) begin
    if (!reset) begin
      if (pulse_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pulse_unexpected: got width %0d expected none", cyc - rise_cyc);
      end else begin
        int w;
        w = pulse_q.pop_front();
        check("pulse_width", cyc - rise_cyc, w);
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic expect_rd(input logic [1:0] a, input logic [31:0] v, input string name);
    exp_t e;
    e.name = name; e.is_pin = 1'b0; e.val = v;
    exp_q.push_back(e);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    probe      = 1'b1;
    @(posedge clk);
    #1;
    probe      = 1'b0;
    chipselect = 1'b0;
  endtask

  // Expected value is {irq, out_port}.
  task automatic expect_pin(input logic [1:0] v, input string name);
    exp_t e;
    e.name = name; e.is_pin = 1'b1; e.val = {30'b0, v};
    exp_q.push_back(e);
    probe = 1'b1;
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values
    expect_rd(A_STATUS, 32'h0, "rst_status");
    expect_rd(A_PULSE, 32'd500, "rst_pulse_len");
    expect_rd(A_HOLD, 32'd6500, "rst_hold_len");
    expect_rd(A_CTRL, 32'h0, "rst_ctrl");
    expect_pin(2'b00, "rst_pins");

    // Reset mid-pulse
    bus_write(A_PULSE, 32'd100);
    bus_write(A_CTRL, 32'h2);
    idle(49);
    expect_pin(2'b01, "midpulse_high");
    reset = 1'b1;
    expect_pin(2'b00, "midpulse_reset_low");
    expect_rd(A_STATUS, 32'h0, "midpulse_reset_status");
    reset = 1'b0;
    expect_rd(A_PULSE, 32'd500, "midpulse_pulse_len");
    expect_rd(A_STATUS, 32'h0, "midpulse_status_after");

    // Basic pulse: 10 high, 5 hold-off
    bus_write(A_PULSE, 32'd10);
    bus_write(A_HOLD, 32'hFFFF_0005);
    expect_rd(A_HOLD, 32'd5, "hold_upper_bits_ignored");
    pulse_q.push_back(10);
    bus_write(A_CTRL, 32'h2);
    expect_rd(A_STATUS, 32'h9, "basic_first_cycle");
    idle(8);
    expect_pin(2'b01, "basic_last_pulse_cycle");
    expect_rd(A_STATUS, 32'h1, "basic_first_hold");
    idle(3);
    expect_rd(A_STATUS, 32'h1, "basic_last_hold");
    expect_rd(A_STATUS, 32'h2, "basic_done");
    bus_write(A_STATUS, 32'h2);
    expect_rd(A_STATUS, 32'h0, "basic_done_cleared");

    // Zero lengths: one-cycle pulse, no hold-off
    bus_write(A_PULSE, 32'd0);
    bus_write(A_HOLD, 32'd0);
    pulse_q.push_back(1);
    bus_write(A_CTRL, 32'h2);
    expect_rd(A_STATUS, 32'h9, "zero_pulse_cycle");
    expect_rd(A_STATUS, 32'h2, "zero_done_next");
    bus_write(A_STATUS, 32'h2);

    // Overrun and reprogram during busy
    bus_write(A_PULSE, 32'd20);
    pulse_q.push_back(20);
    bus_write(A_CTRL, 32'h2);
    idle(4);
    bus_write(A_CTRL, 32'h2);
    bus_write(A_PULSE, 32'd3);
    expect_rd(A_STATUS, 32'hD, "ovr_flagged");
    idle(12);
    expect_rd(A_STATUS, 32'hD, "ovr_still_running");
    expect_rd(A_STATUS, 32'h6, "ovr_done");
    bus_write(A_STATUS, 32'h6);
    expect_rd(A_STATUS, 32'h0, "ovr_cleared");
    pulse_q.push_back(3);
    bus_write(A_CTRL, 32'h2);
    idle(3);
    expect_rd(A_STATUS, 32'h2, "reprog_done");
    bus_write(A_STATUS, 32'h2);

    // Static CE plus IRQ
    bus_write(A_PULSE, 32'd4);
    bus_write(A_CTRL, 32'h5);
    bus_write(A_CTRL, 32'h7);
    expect_pin(2'b01, "static_pulse_start");
    expect_rd(A_STATUS, 32'h9, "static_busy");
    idle(1);
    expect_pin(2'b01, "static_pulse_end");
    expect_pin(2'b11, "static_irq_rise");
    expect_rd(A_STATUS, 32'hA, "static_done");
    bus_write(A_STATUS, 32'h2);
    expect_pin(2'b01, "static_irq_dropped");
    expect_rd(A_CTRL, 32'h5, "static_ctrl_readback");
    bus_write(A_CTRL, 32'h7);
    idle(3);
    bus_write(A_STATUS, 32'h2);
    expect_rd(A_STATUS, 32'hA, "set_beats_clear");
    expect_pin(2'b11, "set_beats_clear_irq");

    idle(2);
    check("pulse_q_drained", pulse_q.size(), 0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/nrf_ce_pulser.md
Name: nrf_ce_pulser

Overview:
Avalon-MM slave that drives the nRF24L01+ CE pin and replaces bit-banged CE control from the Nios II. Produces a static CE level for RX, or a hardware-timed CE pulse for TX followed by a settle hold-off. Completion is reported by a busy flag, a sticky done flag and an optional IRQ. Sits between the Nios data master and the radio CE pad, at the same bus position as the plain CE PIO.

Parameters:
CNT_W, 16, width of the pulse and hold-off counters and registers
DEF_PULSE, 500, reset value of PULSE_LEN in clk cycles (10 us at 50 MHz)
DEF_HOLD, 6500, reset value of HOLD_LEN in clk cycles (130 us at 50 MHz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational from address, zero-extended
out_port  out  1  CE pin drive
irq  out  1  level interrupt, high while done & irq_en

Behaviour:
- Write = chipselect & ~write_n. Reads have no side effects. Zero wait states.
- Register map:
  - 0 CTRL: bit0 ce_static (rw), bit1 start (write-1 pulse, reads 0), bit2 irq_en (rw).
  - 1 PULSE_LEN: [CNT_W-1:0] rw.
  - 2 HOLD_LEN: [CNT_W-1:0] rw.
  - 3 STATUS: bit0 busy (ro), bit1 done (sticky, write-1-clear), bit2 overrun (sticky, write-1-clear), bit3 out_port (ro).
- Reset values: out_port 0, irq 0, ce_static 0, irq_en 0, done 0, overrun 0, PULSE_LEN DEF_PULSE, HOLD_LEN DEF_HOLD, FSM IDLE, counter 0. Reset forces out_port low immediately, mid-pulse included.
- FSM states:
  - IDLE: a start write at edge N moves to PULSE at N+1. The counter loads max(PULSE_LEN,1)-1.
  - PULSE: counter decrements each cycle. At 0: if HOLD_LEN=0, go to IDLE and set done; otherwise go to HOLD and load HOLD_LEN-1.
  - HOLD: counter decrements. At 0, go to IDLE and set done.
- Timing: pulse_active is registered and high for exactly max(PULSE_LEN,1) cycles, starting at N+1. Then HOLD_LEN cycles of hold-off follow. done rises on the edge that enters IDLE.
- out_port = ce_static | (state==PULSE), from registered state. No glitches.
- busy = (state != IDLE).
- A start while busy is ignored, sets overrun and leaves the FSM untouched.
- PULSE_LEN/HOLD_LEN writes during busy are accepted and take effect at the next load. A running count is unaffected.
- Same-cycle done set and W1C clear: set wins. The same rule applies to overrun.
- A CTRL write carrying both start=1 and a ce_static change applies both on the same edge.
- irq = done & irq_en, registered-source, level until cleared.
- Width: counters are CNT_W unsigned. Upper writedata bits are ignored. Register reads are zero-extended to 32.

Decomposition:
- Package nrf_ce_pkg holds:
  - address constants ADDR_CTRL/ADDR_PULSE/ADDR_HOLD/ADDR_STATUS;
  - CTRL/STATUS bit index constants;
  - the FSM state enum {IDLE, PULSE, HOLD};
  - DEF_PULSE/DEF_HOLD defaults.
- One sub-module, nrf_ce_timer, contains the FSM plus down-counter with load/start/busy/done_pulse interface. The top holds the register file, bus decode and readdata mux.

Test Plan:
- Reset mid-pulse: PULSE_LEN=100, start, assert reset at cycle 50 -> out_port 0 same cycle, STATUS reads 0x0, PULSE_LEN reads 500 after release.
- Basic pulse: PULSE_LEN=10, HOLD_LEN=5, start at edge N -> out_port high at N+1..N+10, busy until N+15, done=1 at N+16, STATUS=0x2.
- Zero lengths: PULSE_LEN=0, HOLD_LEN=0, start -> out_port high exactly 1 cycle, done set on the following edge, no HOLD state.
- Overrun plus reprogram: start with PULSE_LEN=20, write start again at cycle 5 and PULSE_LEN=3 at cycle 6 -> pulse stays 20 cycles, overrun=1; next start gives a 3-cycle pulse.
- Static plus IRQ: ce_static=1, irq_en=1, pulse of 4 -> out_port stays 1 throughout. irq rises with done. Writing STATUS 0x2 drops irq. If a clear coincides with done set, done stays 1.
